// File: rtl/host_run_ctrl.sv
// host_run_ctrl
//   Host-side initiator for the 9-bit accumulator core. A run has five phases:
//   load operand words from the host into data memory, pulse req, wait for the
//   core's done, stream the result window back to the host, then pulse finished.
//   While the core is idle this block owns the data-memory host port.
//
// Optional feature macro: HOST_RUN_CYCLE_COUNT_EN
//   defined   -> cycle_count counts RUN cycles (saturating, cleared on start)
//   undefined -> cycle_count is tied to 0
//
// Ports
//   clk, reset              rising-edge clock, async active-low reset
//   start                   begin a run (only looked at in IDLE)
//   in_valid/in_ready/in_data   operand stream from the host
//   mem_wr_en/mem_addr/mem_wdata/mem_rdata  data-memory host port
//                           (mem_rdata is combinational on mem_addr)
//   req, done               start request / finished level from the core
//   out_valid/out_ready/out_data  result stream to the host
//   busy                    any state other than IDLE
//   finished                one-cycle pulse on normal completion
//   timeout_err             sticky abort flag, cleared by the next start
//   cycle_count             RUN-phase cycle count
module host_run_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int LOAD_BASE   = 0,
    parameter int LOAD_LEN    = 64,
    parameter int RESULT_BASE = 64,
    parameter int RESULT_LEN  = 32,
    parameter int TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              req,
    input  logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err,
    output logic [15:0]       cycle_count
);

    localparam int IDX_MAX = (LOAD_LEN > RESULT_LEN) ? LOAD_LEN : RESULT_LEN;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int TMR_W   = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]  LOAD_LAST     = IDX_W'(LOAD_LEN - 1);
    localparam logic [IDX_W-1:0]  RESULT_LAST   = IDX_W'(RESULT_LEN - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST      = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LOAD_BASE_A   = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] RESULT_BASE_A = ADDR_W'(RESULT_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_RUN, S_DRAIN, S_FIN
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] timer;
    logic             armed;
    logic             run_done;
    logic             run_expire;

    // done only counts once it has been seen low inside this RUN, so a level
    // left high by the previous run cannot end the new one. Completion beats
    // the timeout when both land in the same cycle.
    assign run_done   = (state == S_RUN) && armed && done;
    assign run_expire = (state == S_RUN) && !run_done && (timer == TMR_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (in_valid && idx == LOAD_LAST) state_nx = S_REQ;
            S_REQ:   state_nx = S_RUN;
            S_RUN: begin
                if (run_done)        state_nx = S_DRAIN;
                else if (run_expire) state_nx = S_IDLE;
            end
            S_DRAIN: if (out_ready && idx == RESULT_LAST) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        req       = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        finished  = 1'b0;
        case (state)
            S_IDLE: busy = 1'b0;
            S_LOAD: begin
                in_ready  = 1'b1;
                mem_wr_en = in_valid;
                mem_addr  = LOAD_BASE_A + ADDR_W'(idx);
                mem_wdata = in_data;
            end
            S_REQ: req = 1'b1;
            S_DRAIN: begin
                out_valid = 1'b1;
                mem_addr  = RESULT_BASE_A + ADDR_W'(idx);
                out_data  = mem_rdata;
            end
            S_FIN: finished = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // idx is shared by load and drain; it is back at zero when load finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            timer       <= '0;
            armed       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    idx         <= '0;
                    timeout_err <= 1'b0;
                end
                S_LOAD: if (in_valid) idx <= (idx == LOAD_LAST) ? '0 : idx + 1'b1;
                S_REQ: begin
                    timer <= '0;
                    armed <= 1'b0;
                end
                S_RUN: begin
                    timer <= timer + 1'b1;
                    if (!done)      armed       <= 1'b1;
                    if (run_expire) timeout_err <= 1'b1;
                end
                S_DRAIN: if (out_ready) idx <= (idx == RESULT_LAST) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HOST_RUN_CYCLE_COUNT_EN
    logic [15:0] run_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    run_cycles <= '0;
        else if (state == S_IDLE && start)             run_cycles <= '0;
        else if (state == S_RUN && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
    end

    assign cycle_count = run_cycles;
`else
    assign cycle_count = '0;
`endif

endmodule
